// File: rtl/ofifo_pkg.sv
// Shared constants and helpers for the output-side de-skew buffer.
package ofifo_pkg;

  localparam int COL         = 8;
  localparam int PSUM_BW     = 16;
  localparam int OFIFO_DEPTH = 64;

  // Pointer width: index bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ofifo_lane.sv
// One column lane: a depth-entry memory with wrap-bit read/write pointers.
// The caller qualifies i_push (lane not full) and i_pop (all lanes valid).
module ofifo_lane
  import ofifo_pkg::*;
#(
  parameter int bw    = PSUM_BW,
  parameter int depth = OFIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [bw-1:0] i_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [bw-1:0] o_head
);

  localparam int PW = ptr_width(depth);
  localparam int AW = PW - 1;

  logic [bw-1:0] r_mem [depth];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;

  logic [AW-1:0] w_widx;
  logic [AW-1:0] w_ridx;

  assign w_widx  = r_wptr[AW-1:0];
  assign w_ridx  = r_rptr[AW-1:0];

  // Equal pointers mean empty; equal index with differing wrap bits means full.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (w_widx == w_ridx) && (r_wptr[PW-1] != r_rptr[PW-1]);
  assign o_head  = r_mem[w_ridx];

  // Storage array; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[w_widx] <= i_data;
    end
  end

  // Pointer advance; depth is a power of two so natural overflow wraps mod 2*depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= {PW{1'b0}};
      r_rptr <= {PW{1'b0}};
    end else begin
      if (i_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (i_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/ofifo.sv
// Output de-skew buffer: independent per-column writes, aligned row reads.
// A row is presented (first-word-fall-through) only once every lane holds data.
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col   = COL,
  parameter int bw    = PSUM_BW,
  parameter int depth = OFIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [col-1:0]    wr,
  input  logic [col*bw-1:0] in,
  input  logic              rd,
  output logic [col*bw-1:0] out,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_overflow,
  output logic              o_underflow
);

  logic [col-1:0]    w_empty;
  logic [col-1:0]    w_full;
  logic [col-1:0]    w_push;
  logic              w_pop;
  logic [col*bw-1:0] w_head;
  logic              r_overflow;
  logic              r_underflow;

  // A pop advances every lane together, and only when a complete row exists.
  assign w_pop = rd & o_valid;

  // Writes into a full lane are dropped; the full test uses the pre-edge state.
  assign w_push = wr & ~w_full;

  for (genvar g = 0; g < col; g++) begin : g_lane
    ofifo_lane #(
      .bw    (bw),
      .depth (depth)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push[g]),
      .i_pop   (w_pop),
      .i_data  (in[g*bw +: bw]),
      .o_empty (w_empty[g]),
      .o_full  (w_full[g]),
      .o_head  (w_head[g*bw +: bw])
    );
  end

  assign o_valid     = &(~w_empty);
  assign o_full      = |w_full;
  assign o_ready     = ~o_full;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

  // Head row is shown only while it is complete; otherwise the bus reads zero.
  always_comb begin
    out = {(col*bw){1'b0}};
    if (o_valid) begin
      out = w_head;
    end else begin
      out = {(col*bw){1'b0}};
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (|(wr & w_full)) begin
        r_overflow <= 1'b1;
      end
      if (rd && !o_valid) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ofifo.sv
// Self-checking bench for ofifo: directed scenarios plus random traffic,
// compared every cycle against a per-lane queue model of the buffer.
module tb_ofifo;

  localparam int NC = 8;
  localparam int BW = 16;
  localparam int DP = 64;

  logic             clk;
  logic             reset;
  logic [NC-1:0]    wr;
  logic [NC*BW-1:0] in_d;
  logic             rd;
  logic [NC*BW-1:0] out;
  logic             o_valid;
  logic             o_full;
  logic             o_ready;
  logic             o_overflow;
  logic             o_underflow;

  ofifo #(.col(NC), .bw(BW), .depth(DP)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .in          (in_d),
    .rd          (rd),
    .out         (out),
    .o_valid     (o_valid),
    .o_full      (o_full),
    .o_ready     (o_ready),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per lane plus the two sticky flags.
  logic [BW-1:0] q [NC][$];
  bit            m_ovf;
  bit            m_udf;
  int            pops;
  int            n_total;
  int            n_pass;

  task automatic chk(input string tag, input logic [NC*BW-1:0] got, input logic [NC*BW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic bit model_valid();
    bit v;
    v = 1'b1;
    for (int i = 0; i < NC; i++) begin
      if (q[i].size() == 0) v = 1'b0;
    end
    return v;
  endfunction

  function automatic bit model_full();
    bit f;
    f = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (q[i].size() == DP) f = 1'b1;
    end
    return f;
  endfunction

  task automatic model_edge(input logic [NC-1:0] w, input logic [NC*BW-1:0] d, input logic r, input logic rst);
    bit v;
    if (rst) begin
      for (int i = 0; i < NC; i++) q[i].delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      v = model_valid();
      for (int i = 0; i < NC; i++) begin
        if (w[i]) begin
          if (q[i].size() == DP) m_ovf = 1'b1;
          else q[i].push_back(d[i*BW +: BW]);
        end
      end
      if (r) begin
        if (v) begin
          for (int i = 0; i < NC; i++) void'(q[i].pop_front());
          pops++;
        end else begin
          m_udf = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [NC*BW-1:0] exp_out;
    bit               v;
    v = model_valid();
    exp_out = '0;
    if (v) begin
      for (int i = 0; i < NC; i++) exp_out[i*BW +: BW] = q[i][0];
    end
    chk("valid", {127'd0, o_valid}, {127'd0, v});
    chk("full", {127'd0, o_full}, {127'd0, model_full()});
    chk("ready", {127'd0, o_ready}, {127'd0, !model_full()});
    chk("out", out, exp_out);
    chk("overflow", {127'd0, o_overflow}, {127'd0, m_ovf});
    chk("underflow", {127'd0, o_underflow}, {127'd0, m_udf});
  endtask

  // One clock: drive inputs, take the edge, update model, check at the falling edge.
  task automatic step(input logic [NC-1:0] w, input logic [NC*BW-1:0] d, input logic r, input logic rst);
    wr    = w;
    in_d  = d;
    rd    = r;
    reset = rst;
    @(posedge clk);
    model_edge(w, d, r, rst);
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [NC*BW-1:0] row_of(input int v);
    logic [NC*BW-1:0] d;
    for (int i = 0; i < NC; i++) d[i*BW +: BW] = 16'(v);
    return d;
  endfunction

  initial begin
    logic [NC-1:0]    w;
    logic [NC*BW-1:0] d;
    logic [NC*BW-1:0] k;
    clk = 1'b0; wr = '0; in_d = '0; rd = 1'b0; reset = 1'b1;
    n_total = 0; n_pass = 0; pops = 0;
    m_ovf = 1'b0; m_udf = 1'b0;

    // Reset for two cycles.
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    chk("rst_valid", {127'd0, o_valid}, 128'd0);
    chk("rst_full", {127'd0, o_full}, 128'd0);
    chk("rst_ready", {127'd0, o_ready}, 128'd1);
    chk("rst_out", out, 128'd0);
    chk("rst_flags", {126'd0, o_overflow, o_underflow}, 128'd0);

    // Skewed write: lane i writes 0x0100+i at cycle i.
    for (int i = 0; i < NC; i++) d[i*BW +: BW] = 16'h0100 + 16'(i);
    for (int c = 0; c < NC; c++) begin
      step(8'(1 << c), d, 1'b0, 1'b0);
      if (c < NC - 1) chk("skew_valid_early", {127'd0, o_valid}, 128'd0);
    end
    k = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
    chk("skew_valid", {127'd0, o_valid}, 128'd1);
    chk("skew_row", out, k);
    step('0, '0, 1'b1, 1'b0);
    chk("skew_drained", {127'd0, o_valid}, 128'd0);

    // Streaming: 20 skewed rows, pop whenever a row is complete.
    step('0, '0, 1'b0, 1'b1);
    pops = 0;
    for (int c = 0; c < 28; c++) begin
      w = '0;
      d = '0;
      for (int i = 0; i < NC; i++) begin
        if (c - i >= 0 && c - i < 20) begin
          w[i] = 1'b1;
          d[i*BW +: BW] = 16'((c - i) * 16 + i);
        end
      end
      step(w, d, model_valid(), 1'b0);
    end
    chk("stream_pops", 128'(pops), 128'd20);
    chk("stream_empty", {127'd0, o_valid}, 128'd0);

    // Fill every lane, overflow once, drain, then stream through the wrap.
    step('0, '0, 1'b0, 1'b1);
    for (int r = 0; r < DP; r++) step('1, row_of(r), 1'b0, 1'b0);
    chk("fill_full", {127'd0, o_full}, 128'd1);
    chk("fill_ready", {127'd0, o_ready}, 128'd0);
    chk("fill_ovf_clear", {127'd0, o_overflow}, 128'd0);
    step('1, row_of(16'hdead), 1'b0, 1'b0);
    chk("ovf_set", {127'd0, o_overflow}, 128'd1);
    for (int r = 0; r < DP; r++) begin
      chk("full_readback", out, row_of(r));
      step('0, '0, 1'b1, 1'b0);
    end
    chk("drained_valid", {127'd0, o_valid}, 128'd0);
    for (int r = DP; r < 200; r++) step('1, row_of(r), model_valid(), 1'b0);
    chk("wrap_last", out, row_of(199));

    // Boundaries: read while empty, then write+pop with one entry stored.
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b1, 1'b0);
    chk("udf_set", {127'd0, o_underflow}, 128'd1);
    chk("udf_valid", {127'd0, o_valid}, 128'd0);
    step('1, row_of(16'h00aa), 1'b0, 1'b0);
    chk("after_udf_row", out, row_of(16'h00aa));
    step('1, row_of(16'h00bb), 1'b1, 1'b0);
    chk("wp_valid", {127'd0, o_valid}, 128'd1);
    chk("wp_row", out, row_of(16'h00bb));
    step('0, '0, 1'b1, 1'b0);
    chk("wp_occ_one", {127'd0, o_valid}, 128'd0);

    // Reset mid-stream with five rows stored; reset wins over wr/rd.
    for (int r = 0; r < 5; r++) step('1, row_of(r + 16'h0500), 1'b0, 1'b0);
    chk("mid_valid", {127'd0, o_valid}, 128'd1);
    step('1, row_of(16'hbeef), 1'b1, 1'b1);
    chk("mid_rst_valid", {127'd0, o_valid}, 128'd0);
    chk("mid_rst_flags", {126'd0, o_overflow, o_underflow}, 128'd0);
    step('1, row_of(16'h1234), 1'b0, 1'b0);
    chk("mid_fresh_row", out, row_of(16'h1234));

    // Random traffic: slow reads first to reach full lanes, then faster reads.
    for (int c = 0; c < 900; c++) begin
      w = 8'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom};
      if (c < 400) step(w, d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
      else step(w, d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
